light_show_sequencer: RTL and testbench
=======================================

LIGHT_SHOW_SEQUENCER -- requirements
Module: light_show_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 4: number of pattern engines sequenced.
REQ-002 Parameter CLKS_PER_MS, default 50000: clk cycles per millisecond tick.
REQ-003 Parameter GAP_MS, default 500: all-lights-off interval between patterns, in ms.
REQ-004 Parameter TIMEOUT_MS, default 30000: watchdog limit per pattern, in ms.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 run  in  1  level; 1 = sequence the show, 0 = stop and return to idle.
REQ-008 pat_mask  in  NUM_PATTERNS  bit i = 1 enables pattern i.
REQ-009 pat_finished  in  NUM_PATTERNS  per-engine done flag, bit i from engine i.
REQ-010 pat_lights  in  8*NUM_PATTERNS  engine i drives bits [8i+7:8i].
REQ-011 pat_go  out  NUM_PATTERNS  one-cycle start pulse to engine i.
REQ-012 lights  out  8  registered light drive to the string.
REQ-013 active_idx  out  clog2(NUM_PATTERNS)  index of the current or most recent pattern.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 timeout_err  out  1  sticky; set when any pattern hits the watchdog.

Function
REQ-016 FSM states: IDLE, SELECT, LAUNCH, RUN, GAP.
REQ-017 IDLE -> SELECT when run=1 and pat_mask!=0; otherwise stay in IDLE.
REQ-018 SELECT: one cycle.
- Chooses the next enabled index by rotating search starting at active_idx+1, wrapping NUM_PATTERNS-1 -> 0.
- The first selection after IDLE starts the search at index 0.
REQ-019 A single enabled pattern is reselected every round.
REQ-020 pat_mask is sampled only in SELECT. If pat_mask=0 in SELECT: go to IDLE, no pat_go issued.
REQ-021 LAUNCH: pat_go[active_idx]=1 for exactly one cycle, then RUN; at most one pat_go bit is ever high.
REQ-022 RUN:
- lights <= pat_lights slice of active_idx, registered, one-cycle latency.
- pat_finished[active_idx]=1 -> GAP.
- pat_finished bits of other indices are ignored.
- pat_finished is ignored in LAUNCH and is first sampled in the first RUN cycle.
REQ-023 Watchdog: ms counter cleared on LAUNCH. In RUN, reaching TIMEOUT_MS ms -> set timeout_err, then GAP.
REQ-024 If finished and timeout occur in the same cycle, finished wins and timeout_err is not set.
REQ-025 GAP: lights=0 for GAP_MS ms, then SELECT. GAP_MS=0 -> exactly one GAP cycle.
REQ-026 run=0 in any state: next cycle IDLE, lights=0, no pat_go.
REQ-027 timeout_err is cleared only by rst, or by a run 0->1 transition.
REQ-028 ms tick: counter 0..CLKS_PER_MS-1, tick on terminal count.
- Counter restarts at LAUNCH and at GAP entry.
- The ms accumulator width holds max(TIMEOUT_MS, GAP_MS) and never wraps.

Reset
REQ-029 rst=1 asynchronously forces:
- state IDLE, pat_go=0, lights=0, active_idx=0, busy=0, timeout_err=0.
- all counters 0.
REQ-030 rst asserted mid-pattern forces all outputs to 0 immediately; sequencing restarts from index 0 after release.

Structure
REQ-031 Package light_show_pkg holds:
- state enum type.
- LIGHTS_PER_PATTERN=8.
- default NUM_PATTERNS.
REQ-032 Sub-module ms_tick_gen (clk, rst, clear, tick) generates the ms tick; the next-index search stays inline.

Verification
All scenarios use CLKS_PER_MS=10, GAP_MS=2, TIMEOUT_MS=5.
REQ-033 mask=4'b1111, run=1, each engine finishes 20 clk after its go -> pat_go order 0,1,2,3,0; 20 clk of lights=0 between patterns.
REQ-034 mask=4'b0101 -> pat_go order 0,2,0,2; bits 1 and 3 of pat_go never high.
REQ-035 Engine 1 never finishes -> 50 clk after go[1]: timeout_err=1, GAP, then pat_go[2]; timeout_err stays 1.
REQ-036 run dropped during RUN of pattern 2 -> next cycle busy=0, lights=0; run reasserted -> first pat_go is index 0, timeout_err=0.
REQ-037 pat_finished[3]=1 while index 1 is active -> ignored, stays in RUN; rst pulse mid-RUN -> all outputs 0 in the same cycle.
REQ-038 mask=0 with run=1 -> busy stays 0 and pat_go stays 0 for 100 clk.

Source files
------------

// File: rtl/light_show_pkg.sv
// light_show_pkg: shared state type and constants for the light show sequencer.
package light_show_pkg;
   localparam int LIGHTS_PER_PATTERN = 8;
   localparam int DEFAULT_NUM_PATTERNS = 4;
   typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, RUN, GAP} state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: divides clk down to a one-cycle millisecond tick, restartable via clear.
module ms_tick_gen #(
   parameter int CLKS_PER_MS = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int W = CLKS_PER_MS > 1 ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_MS - 1);
   logic [W-1:0] cnt;
   assign tick = cnt == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/light_show_sequencer.sv
// light_show_sequencer: rotates through enabled pattern engines with a timed
// all-off gap between them and a per-pattern watchdog.
module light_show_sequencer
   import light_show_pkg::*;
#(
   parameter int NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
   parameter int CLKS_PER_MS = 50000,
   parameter int GAP_MS = 500,
   parameter int TIMEOUT_MS = 30000,
   localparam int IW = NUM_PATTERNS > 1 ? $clog2(NUM_PATTERNS) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     run,
   input  logic [NUM_PATTERNS-1:0]                  pat_mask,
   input  logic [NUM_PATTERNS-1:0]                  pat_finished,
   input  logic [LIGHTS_PER_PATTERN*NUM_PATTERNS-1:0] pat_lights,
   output logic [NUM_PATTERNS-1:0]                  pat_go,
   output logic [LIGHTS_PER_PATTERN-1:0]            lights,
   output logic [IW-1:0]                            active_idx,
   output logic                                     busy,
   output logic                                     timeout_err
);
   localparam int MAX_MS = TIMEOUT_MS > GAP_MS ? TIMEOUT_MS : GAP_MS;
   localparam int MW = $clog2(MAX_MS + 1) > 0 ? $clog2(MAX_MS + 1) : 1;
   localparam logic [MW-1:0] TO_LAST = TIMEOUT_MS > 0 ? MW'(TIMEOUT_MS - 1) : '0;
   localparam logic [MW-1:0] GAP_LAST = GAP_MS > 0 ? MW'(GAP_MS - 1) : '0;
   state_t state, nxt;
   logic [MW-1:0] ms_cnt;
   logic [IW-1:0] sel_idx;
   logic [LIGHTS_PER_PATTERN-1:0] cur_lights;
   logic tick, clear, fresh, run_q, finished, to_hit, gap_done, found;
   int base, j;
   ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .tick(tick)
   );
   assign finished = pat_finished[active_idx];
   assign to_hit = TIMEOUT_MS == 0 || (tick && ms_cnt == TO_LAST);
   assign gap_done = GAP_MS == 0 || (tick && ms_cnt == GAP_LAST);
   assign busy = state != IDLE;
   assign clear = (state != RUN && state != GAP) || (state == RUN && nxt == GAP);
   assign pat_go = (state == LAUNCH && run) ? NUM_PATTERNS'(1) << active_idx : '0;
   assign cur_lights = LIGHTS_PER_PATTERN'(pat_lights >> (int'(active_idx) * LIGHTS_PER_PATTERN));
   // Scan backwards so the nearest enabled index in rotation order wins.
   always_comb begin
      found = 1'b0;
      sel_idx = active_idx;
      j = 0;
      base = fresh ? 0 : int'(active_idx) + 1;
      for (int k = NUM_PATTERNS - 1; k >= 0; k--) begin
         j = (base + k) % NUM_PATTERNS;
         if (pat_mask[IW'(j)]) begin
            found = 1'b1;
            sel_idx = IW'(j);
         end
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (run && |pat_mask) ? SELECT : IDLE;
         SELECT:  nxt = found ? LAUNCH : IDLE;
         LAUNCH:  nxt = RUN;
         RUN:     nxt = (finished || to_hit) ? GAP : RUN;
         GAP:     nxt = gap_done ? SELECT : GAP;
         default: nxt = IDLE;
      endcase
      if (!run) nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         active_idx <= '0;
         fresh <= 1'b1;
         run_q <= 1'b0;
         ms_cnt <= '0;
         lights <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= nxt;
         run_q <= run;
         fresh <= state == IDLE ? 1'b1 : state == SELECT ? 1'b0 : fresh;
         if (state == SELECT && found) active_idx <= sel_idx;
         ms_cnt <= clear ? '0 : ms_cnt + MW'(tick);
         lights <= nxt == RUN ? cur_lights : '0;
         // A finish in the same cycle as the watchdog expiry takes priority.
         timeout_err <= (run && !run_q) ? 1'b0
                      : timeout_err | (state == RUN && run && !finished && to_hit);
      end
endmodule

// File: tb/tb_light_show_sequencer.sv
// tb_light_show_sequencer: randomized scenarios checked against a timeline model.
module tb_light_show_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic [3:0] pat_mask = 4'b0;
   logic [3:0] fin = 4'b0;
   logic [3:0] force_fin = 4'b0;
   logic [3:0] pat_finished;
   logic [3:0] pat_go;
   logic [31:0] pat_lights;
   logic [7:0] lights;
   logic [7:0] lit [4];
   logic [1:0] active_idx;
   logic busy, timeout_err;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int dly [4];
   int cnt [4];

   assign pat_finished = fin | force_fin;
   assign pat_lights = {lit[3], lit[2], lit[1], lit[0]};

   light_show_sequencer #(
      .NUM_PATTERNS(4),
      .CLKS_PER_MS(10),
      .GAP_MS(2),
      .TIMEOUT_MS(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .pat_mask(pat_mask),
      .pat_finished(pat_finished),
      .pat_lights(pat_lights),
      .pat_go(pat_go),
      .lights(lights),
      .active_idx(active_idx),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine models: finish dly[i] cycles after their go; dly 0 means never finish.
   initial begin
      for (int i = 0; i < 4; i++) begin
         cnt[i] = -1;
         dly[i] = 0;
         lit[i] = 8'h00;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            fin[i] = 1'b0;
            if (pat_go[i]) cnt[i] = dly[i] == 0 ? -1 : dly[i];
            else if (cnt[i] > 0) begin
               cnt[i] = cnt[i] - 1;
               fin[i] = cnt[i] == 0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got cyc=%0d required finish", cyc);
      $fatal(1, "timeout");
   end

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (pat_go !== 4'b0) begin bad++; $display("FAIL reset_go got=%b exp=0000", pat_go); end
      total++; if (lights !== 8'h0) begin bad++; $display("FAIL reset_lights got=%h exp=00", lights); end
      total++; if (active_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", active_idx); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Builds the expected go timeline from the rotation rule and per-pattern
   // durations, then checks every cycle of the show against it.
   task automatic test_rotation(input logic [3:0] mask, input int rounds);
      int s_idx[$], s_t[$], s_eff[$], s_to[$];
      int prev, t, c0, idx, eff, eidx, last, jj;
      logic [3:0] eg;
      logic [7:0] el;
      logic ete;
      run = 1'b0;
      force_fin = 4'b0;
      repeat (2) @(negedge clk);
      pat_mask = mask;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = -1;
         lit[i] = 8'($urandom_range(1, 255));
      end
      run = 1'b1;
      c0 = cyc;
      prev = -1;
      t = c0 + 2;
      for (int r = 0; r < rounds; r++) begin
         idx = -1;
         for (int k = 1; k <= 4 && idx < 0; k++) begin
            jj = (prev + k) % 4;
            if (((mask >> jj) & 4'd1) != 4'd0) idx = jj;
         end
         eff = (dly[idx] == 0 || dly[idx] > 50) ? 50 : dly[idx];
         s_idx.push_back(idx);
         s_t.push_back(t);
         s_eff.push_back(eff);
         s_to.push_back((dly[idx] == 0 || dly[idx] > 50) ? 1 : 0);
         t = t + eff + 22;
         prev = idx;
      end
      last = s_t[rounds - 1] + 3;
      for (int c = c0 + 1; c <= last; c++) begin
         @(negedge clk);
         eg = 4'b0;
         el = 8'h0;
         ete = 1'b0;
         eidx = -1;
         foreach (s_t[k]) begin
            if (c == s_t[k]) eg = eg | (4'd1 << s_idx[k]);
            if (c > s_t[k] && c <= s_t[k] + s_eff[k]) el = lit[s_idx[k]];
            if (s_to[k] != 0 && c >= s_t[k] + 51) ete = 1'b1;
            if (c >= s_t[k]) eidx = s_idx[k];
         end
         total++; if (pat_go !== eg) begin bad++; $display("FAIL rot_go mask=%b c=%0d got=%b exp=%b", mask, c - c0, pat_go, eg); end
         total++; if (lights !== el) begin bad++; $display("FAIL rot_lights mask=%b c=%0d got=%h exp=%h", mask, c - c0, lights, el); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL rot_busy mask=%b c=%0d got=%b exp=1", mask, c - c0, busy); end
         total++; if (timeout_err !== ete) begin bad++; $display("FAIL rot_terr mask=%b c=%0d got=%b exp=%b", mask, c - c0, timeout_err, ete); end
         if (eidx >= 0) begin
            total++; if (int'(active_idx) != eidx) begin bad++; $display("FAIL rot_idx mask=%b c=%0d got=%0d exp=%0d", mask, c - c0, active_idx, eidx); end
         end
      end
   endtask

   task automatic test_timeout;
      dly = '{20, 0, 20, 20};
      test_rotation(4'b1111, 3);
      repeat (30) @(negedge clk);
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
   endtask

   task automatic test_run_drop;
      int got, c;
      run = 1'b0;
      repeat (2) @(negedge clk);
      pat_mask = 4'b1111;
      dly = '{20, 0, 0, 0};
      run = 1'b1;
      got = -1;
      for (int n = 0; n < 400 && got < 0; n++) begin
         @(negedge clk);
         if (pat_go == 4'b0100) got = cyc;
      end
      total++; if (got < 0) begin bad++; $display("FAIL drop_go2 got=none exp=go[2]"); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL drop_terr_before got=%b exp=1", timeout_err); end
      repeat (10) @(negedge clk);
      total++; if (lights !== lit[2]) begin bad++; $display("FAIL drop_run_lights got=%h exp=%h", lights, lit[2]); end
      run = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b exp=0", busy); end
      total++; if (lights !== 8'h0) begin bad++; $display("FAIL drop_lights got=%h exp=00", lights); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL drop_terr_hold got=%b exp=1", timeout_err); end
      repeat (3) @(negedge clk);
      run = 1'b1;
      c = cyc;
      @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rerun_terr got=%b exp=0", timeout_err); end
      total++; if (pat_go !== 4'b0) begin bad++; $display("FAIL rerun_early_go got=%b exp=0000 c=%0d", pat_go, cyc - c); end
      @(negedge clk);
      total++; if (pat_go !== 4'b0001) begin bad++; $display("FAIL rerun_first_go got=%b exp=0001", pat_go); end
   endtask

   task automatic test_stray_rst;
      int got;
      run = 1'b0;
      repeat (2) @(negedge clk);
      pat_mask = 4'b1111;
      dly = '{0, 0, 0, 0};
      run = 1'b1;
      got = -1;
      for (int n = 0; n < 300 && got < 0; n++) begin
         @(negedge clk);
         if (pat_go == 4'b0010) got = cyc;
      end
      total++; if (got < 0) begin bad++; $display("FAIL stray_go1 got=none exp=go[1]"); end
      force_fin = 4'b1000;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         total++; if ({busy, pat_go, lights} !== {1'b1, 4'b0, lit[1]}) begin
            bad++; $display("FAIL stray_ignored n=%0d got busy=%b go=%b lights=%h exp busy=1 go=0000 lights=%h", n, busy, pat_go, lights, lit[1]);
         end
      end
      force_fin = 4'b0;
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL stray_terr got=%b exp=1", timeout_err); end
      rst = 1'b1;
      #1;
      total++; if ({pat_go, lights, active_idx, busy, timeout_err} !== 16'h0) begin
         bad++; $display("FAIL async_rst got go=%b lights=%h idx=%0d busy=%b terr=%b exp all 0", pat_go, lights, active_idx, busy, timeout_err);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (pat_go !== 4'b0) begin bad++; $display("FAIL post_rst_early got=%b exp=0000", pat_go); end
      @(negedge clk);
      total++; if (pat_go !== 4'b0001) begin bad++; $display("FAIL post_rst_go got=%b exp=0001", pat_go); end
   endtask

   task automatic test_zero_mask;
      int t;
      run = 1'b0;
      repeat (2) @(negedge clk);
      pat_mask = 4'b0;
      run = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         total++; if ({busy, pat_go} !== 5'b0) begin bad++; $display("FAIL zero_mask n=%0d got busy=%b go=%b exp 0", n, busy, pat_go); end
      end
      run = 1'b0;
      repeat (2) @(negedge clk);
      pat_mask = 4'b0010;
      dly = '{0, 5, 0, 0};
      run = 1'b1;
      repeat (2) @(negedge clk);
      t = cyc;
      total++; if (pat_go !== 4'b0010) begin bad++; $display("FAIL mask_go1 got=%b exp=0010", pat_go); end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 3) pat_mask = 4'b0;
         total++; if (pat_go !== 4'b0) begin bad++; $display("FAIL mask_nogo c=%0d got=%b exp=0000", c, pat_go); end
         if (c == 26) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL mask_select_busy got=%b exp=1", busy); end
         end
         if (c == 27) begin
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mask_idle_busy got=%b exp=0", busy); end
         end
      end
      pat_mask = 4'b0100;
      repeat (2) @(negedge clk);
      total++; if (pat_go !== 4'b0100) begin bad++; $display("FAIL mask_restart got=%b exp=0100 c=%0d", pat_go, cyc - t); end
   endtask

   initial begin
      test_reset;
      dly = '{20, 20, 20, 20};
      test_rotation(4'b1111, 5);
      test_rotation(4'b0101, 4);
      dly = '{7, 7, 7, 7};
      test_rotation(4'b0100, 3);
      dly = '{50, 51, 1, 1};
      test_rotation(4'b0011, 4);
      test_timeout;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 60);
         test_rotation(4'($urandom_range(1, 15)), 4);
      end
      test_run_drop;
      test_stray_rst;
      test_zero_mask;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
